// File: rtl/cmos_cell_driver_if.sv
// Request/response bundle between a controller and the CMOS cell stimulus driver.
// The sweep result is named truth_table because "table" is a reserved word.
interface cmos_cell_driver_if;
    logic        start;
    logic        mode;
    logic [3:0]  vec_in;
    logic        ready;
    logic        result;
    logic        result_valid;
    logic [15:0] truth_table;
    logic        done;

    modport master (
        output start, mode, vec_in,
        input  ready, result, result_valid, truth_table, done
    );

    modport slave (
        input  start, mode, vec_in,
        output ready, result, result_valid, truth_table, done
    );
endinterface

// File: rtl/cmos_cell_driver.sv
// Stimulus driver for a 4-input CMOS cell: drives complementary rails from one register,
// waits SETTLE_CYC cycles, then samples the cell output (single vector or 16-vector sweep).
module cmos_cell_driver #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cmos_cell_driver_if.slave         bus,
    output logic                      a,
    output logic                      b,
    output logic                      c,
    output logic                      d,
    output logic                      not_a,
    output logic                      not_b,
    output logic                      not_c,
    output logic                      not_d,
    input  logic                      cell_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2} state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  drv_q, drv_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic        result_q, result_d;
    logic [15:0] table_q, table_d;
    logic        rv_q, rv_d;
    logic        done_q, done_d;
    logic        ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            drv_q    <= 4'h0;
            cnt_q    <= 4'h0;
            idx_q    <= 4'h0;
            mode_q   <= 1'b0;
            result_q <= 1'b0;
            table_q  <= 16'h0000;
            rv_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drv_q    <= drv_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            table_q  <= table_d;
            rv_q     <= rv_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drv_d    = drv_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        result_d = result_q;
        table_d  = table_q;
        rv_d     = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    drv_d   = bus.mode ? 4'h0 : bus.vec_in;
                    idx_d   = 4'h0;
                    cnt_d   = 4'h0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (!mode_q) begin
                    result_d = cell_out;
                    rv_d     = 1'b1;
                    state_d  = IDLE;
                end else begin
                    table_d[idx_q] = cell_out;
                    // Last vector keeps its rails; the next vector otherwise starts a fresh settle.
                    if (idx_q == 4'hF) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        drv_d   = idx_q + 4'd1;
                        cnt_d   = 4'h0;
                        state_d = SETTLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Both rails derive from drv_q alone, so they can never agree, even in reset.
    always_comb begin
        ready = (state_q == IDLE);
        {a, b, c, d} = drv_q;
        {not_a, not_b, not_c, not_d} = ~drv_q;
    end

    assign bus.ready        = ready;
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.truth_table  = table_q;
    assign bus.done         = done_q;

endmodule
